// File: rtl/maze_tile_renderer.sv
// maze_tile_renderer
//   Three-stage colour pipeline that draws a tiled maze between vga_sync and
//   the VGA pins. Path bits live in an internal RAM behind a write port, a
//   trail RAM remembers every tile the character has stood on at a frame
//   boundary, and the finish tile blinks. Configuration and positions are
//   captured into shadow registers once per frame so nothing tears.
//
// Ports
//   clk, reset                 pixel clock, synchronous active-high reset
//   enable                     0 blanks the colour output only
//   pixel_x/y, video_on,
//   hsync_in, vsync_in         raster position and timing from vga_sync
//   cfg_maze_w/h, cfg_tile_log2,
//   start_*, finish_*, char_*  live configuration, sampled at frame_tick
//   map_wr_en/addr/data        path RAM write port, addr = y*2^MAP_BITS + x
//   trail_clear                pulse: (re)start the trail clear sweep
//   hsync, vsync, rgb          outputs, all 3 cycles after the inputs
//   clear_busy                 trail sweep in progress
//   cfg_err                    latched maze does not fit 640x480
//   frame_tick                 one-cycle pulse at the start of vertical blank
module maze_tile_renderer #(
  parameter int         MAP_BITS     = 5,
  parameter int         BLINK_LOG2   = 4,
  parameter logic [7:0] CHAR_COLOR   = 8'b000_000_11,
  parameter logic [7:0] START_COLOR  = 8'b000_111_00,
  parameter logic [7:0] FINISH_COLOR = 8'b111_000_00,
  parameter logic [7:0] PATH_COLOR   = 8'hFF,
  parameter logic [7:0] TRAIL_COLOR  = 8'b110_110_01
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  input  logic                  video_on,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic [MAP_BITS-1:0]   cfg_maze_w,
  input  logic [MAP_BITS-1:0]   cfg_maze_h,
  input  logic [2:0]            cfg_tile_log2,
  input  logic [MAP_BITS-1:0]   start_x,
  input  logic [MAP_BITS-1:0]   start_y,
  input  logic [MAP_BITS-1:0]   finish_x,
  input  logic [MAP_BITS-1:0]   finish_y,
  input  logic [MAP_BITS-1:0]   char_x,
  input  logic [MAP_BITS-1:0]   char_y,
  input  logic                  map_wr_en,
  input  logic [2*MAP_BITS-1:0] map_wr_addr,
  input  logic                  map_wr_data,
  input  logic                  trail_clear,
  output logic                  hsync,
  output logic                  vsync,
  output logic [7:0]            rgb,
  output logic                  clear_busy,
  output logic                  cfg_err,
  output logic                  frame_tick
);

  localparam int AW    = 2 * MAP_BITS;
  localparam int DEPTH = 1 << AW;
  // 4x4 character sprite: a filled square with its four corners knocked out.
  localparam logic [15:0] SPRITE_MASK = 16'b0110_1111_1111_0110;

  typedef struct packed {
    logic [MAP_BITS-1:0] maze_w;
    logic [MAP_BITS-1:0] maze_h;
    logic [2:0]          tile_log2;
    logic [MAP_BITS-1:0] start_x;
    logic [MAP_BITS-1:0] start_y;
    logic [MAP_BITS-1:0] finish_x;
    logic [MAP_BITS-1:0] finish_y;
    logic [MAP_BITS-1:0] char_x;
    logic [MAP_BITS-1:0] char_y;
  } shadow_t;

  // ---------------- state registers ----------------
  shadow_t             shadow_q, shadow_d;
  logic [BLINK_LOG2:0] frame_cnt_q, frame_cnt_d;
  logic                frame_tick_q, frame_tick_d;
  logic                clr_busy_q, clr_busy_d;
  logic [AW-1:0]       clr_addr_q, clr_addr_d;
  logic                pw_en_q, pw_en_d;
  logic [AW-1:0]       pw_addr_q, pw_addr_d;
  logic                pw_data_q, pw_data_d;
  // S1
  logic [10:0]         dx_q, dx_d, dy_q, dy_d;
  logic                in1_q, in1_d;
  // S2
  logic [MAP_BITS-1:0] tx_q, tx_d, ty_q, ty_d;
  logic [4:0]          ox_q, ox_d, oy_q, oy_d;
  logic                in2_q, in2_d;
  // S3 / delay lines
  logic [7:0]          rgb_q, rgb_d;
  logic [2:0]          hs_q, hs_d, vs_q, vs_d;
  logic [1:0]          von_q, von_d;

  // RAMs with registered read
  logic                path_mem  [DEPTH];
  logic                trail_mem [DEPTH];
  logic                path_rd_q, trail_rd_q;

  // ---------------- combinational signals ----------------
  logic                tick_now;
  logic [2:0]          lg, sub_shift;
  logic [10:0]         mw, mh, bx, by, x_ext, y_ext;
  logic                geom_err;
  logic [4:0]          tile_mask;
  logic [AW-1:0]       rd_addr;
  logic                trail_we, trail_wd;
  logic [AW-1:0]       trail_wa;
  logic [1:0]          spr_r, spr_c;
  logic [3:0]          spr_idx;
  logic                spr_bit, is_char, is_start, is_finish;

  // Geometry from the shadow copy only.
  always_comb begin
    lg = shadow_q.tile_log2;
    if (lg < 3'd2)      lg = 3'd2;
    else if (lg > 3'd5) lg = 3'd5;
    mw        = 11'(shadow_q.maze_w) << lg;
    mh        = 11'(shadow_q.maze_h) << lg;
    geom_err  = (mw > 11'd640) || (mh > 11'd480);
    bx        = (11'd640 - mw) >> 1;
    by        = (11'd480 - mh) >> 1;
    tile_mask = 5'((6'd1 << lg) - 6'd1);
    // Sprite is 4x4 cells, so each cell is 2^(lg-2) pixels.
    sub_shift = lg - 3'd2;
  end

  assign tick_now = (pixel_x == 10'd0) && (pixel_y == 10'd480);

  // Next-state logic for everything except the RAMs.
  always_comb begin
    shadow_d     = shadow_q;
    frame_cnt_d  = frame_cnt_q;
    frame_tick_d = tick_now;
    if (tick_now) begin
      shadow_d.maze_w    = cfg_maze_w;
      shadow_d.maze_h    = cfg_maze_h;
      shadow_d.tile_log2 = cfg_tile_log2;
      shadow_d.start_x   = start_x;
      shadow_d.start_y   = start_y;
      shadow_d.finish_x  = finish_x;
      shadow_d.finish_y  = finish_y;
      shadow_d.char_x    = char_x;
      shadow_d.char_y    = char_y;
      frame_cnt_d        = frame_cnt_q + 1'b1;
    end

    // A new clear request always restarts from address 0.
    clr_busy_d = clr_busy_q;
    clr_addr_d = clr_addr_q;
    if (trail_clear) begin
      clr_busy_d = 1'b1;
      clr_addr_d = '0;
    end else if (clr_busy_q) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (&clr_addr_q) clr_busy_d = 1'b0;
    end

    // The path write is staged one cycle before landing in the RAM.
    pw_en_d   = map_wr_en;
    pw_addr_d = map_wr_addr;
    pw_data_d = map_wr_data;

    // S1: offsets from the maze origin and the inside test.
    x_ext = {1'b0, pixel_x};
    y_ext = {1'b0, pixel_y};
    dx_d  = x_ext - bx;
    dy_d  = y_ext - by;
    in1_d = !geom_err && (x_ext >= bx) && (x_ext < bx + mw) &&
            (y_ext >= by) && (y_ext < by + mh);

    // S2: tile coordinates and intra-tile offsets.
    tx_d  = MAP_BITS'(dx_q >> lg);
    ty_d  = MAP_BITS'(dy_q >> lg);
    ox_d  = 5'(dx_q) & tile_mask;
    oy_d  = 5'(dy_q) & tile_mask;
    in2_d = in1_q;
    rd_addr = {ty_d, tx_d};

    // S3: colour priority.
    spr_r     = 2'(oy_q >> sub_shift);
    spr_c     = 2'(ox_q >> sub_shift);
    spr_idx   = 4'd15 - {spr_r, spr_c};
    spr_bit   = SPRITE_MASK[spr_idx];
    is_char   = (tx_q == shadow_q.char_x)   && (ty_q == shadow_q.char_y);
    is_start  = (tx_q == shadow_q.start_x)  && (ty_q == shadow_q.start_y);
    is_finish = (tx_q == shadow_q.finish_x) && (ty_q == shadow_q.finish_y);
    rgb_d = 8'h00;
    if (in2_q && enable && von_q[1]) begin
      if (is_char && spr_bit)                           rgb_d = CHAR_COLOR;
      else if (is_start)                                rgb_d = START_COLOR;
      else if (is_finish && !frame_cnt_q[BLINK_LOG2])   rgb_d = FINISH_COLOR;
      else if (path_rd_q && trail_rd_q)                 rgb_d = TRAIL_COLOR;
      else if (path_rd_q)                               rgb_d = PATH_COLOR;
    end

    hs_d  = {hs_q[1:0], hsync_in};
    vs_d  = {vs_q[1:0], vsync_in};
    von_d = {von_q[0], video_on};

    // The sweep owns the trail write port; a frame mark during it is lost.
    trail_we = !reset && (clr_busy_q || tick_now);
    trail_wa = clr_busy_q ? clr_addr_q : {char_y, char_x};
    trail_wd = !clr_busy_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q     <= '0;
      frame_cnt_q  <= '0;
      frame_tick_q <= 1'b0;
      clr_busy_q   <= 1'b1;
      clr_addr_q   <= '0;
      pw_en_q      <= 1'b0;
      pw_addr_q    <= '0;
      pw_data_q    <= 1'b0;
      dx_q         <= '0;
      dy_q         <= '0;
      in1_q        <= 1'b0;
      tx_q         <= '0;
      ty_q         <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      in2_q        <= 1'b0;
      rgb_q        <= 8'h00;
      hs_q         <= 3'b111;
      vs_q         <= 3'b111;
      von_q        <= 2'b00;
    end else begin
      shadow_q     <= shadow_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_tick_q <= frame_tick_d;
      clr_busy_q   <= clr_busy_d;
      clr_addr_q   <= clr_addr_d;
      pw_en_q      <= pw_en_d;
      pw_addr_q    <= pw_addr_d;
      pw_data_q    <= pw_data_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      in1_q        <= in1_d;
      tx_q         <= tx_d;
      ty_q         <= ty_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      in2_q        <= in2_d;
      rgb_q        <= rgb_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      von_q        <= von_d;
    end
  end

  // Path RAM: read-before-write, contents survive reset.
  always_ff @(posedge clk) begin
    if (pw_en_q) path_mem[pw_addr_q] <= pw_data_q;
    path_rd_q <= path_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (trail_we) trail_mem[trail_wa] <= trail_wd;
    trail_rd_q <= trail_mem[rd_addr];
  end

  assign rgb        = rgb_q;
  assign hsync      = hs_q[2];
  assign vsync      = vs_q[2];
  assign clear_busy = clr_busy_q;
  assign cfg_err    = geom_err;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_maze_tile_renderer.sv
// Bench for maze_tile_renderer: randomized raster traffic compared every cycle
// against a frame-level reference model, plus directed probes of the maze.
module tb_maze_tile_renderer;

  localparam logic [7:0] C_CHAR   = 8'h03;
  localparam logic [7:0] C_START  = 8'h1C;
  localparam logic [7:0] C_FINISH = 8'hE0;
  localparam logic [7:0] C_PATH   = 8'hFF;
  localparam logic [7:0] C_TRAIL  = 8'hD9;

  logic       clk = 1'b0;
  logic       reset, enable, video_on, hsync_in, vsync_in;
  logic [9:0] pixel_x, pixel_y;
  logic [4:0] cfg_maze_w, cfg_maze_h, start_x, start_y, finish_x, finish_y, char_x, char_y;
  logic [2:0] cfg_tile_log2;
  logic       map_wr_en, map_wr_data, trail_clear;
  logic [9:0] map_wr_addr;
  logic       hsync, vsync, clear_busy, cfg_err, frame_tick;
  logic [7:0] rgb;

  maze_tile_renderer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .cfg_maze_w(cfg_maze_w), .cfg_maze_h(cfg_maze_h), .cfg_tile_log2(cfg_tile_log2),
    .start_x(start_x), .start_y(start_y), .finish_x(finish_x), .finish_y(finish_y),
    .char_x(char_x), .char_y(char_y),
    .map_wr_en(map_wr_en), .map_wr_addr(map_wr_addr), .map_wr_data(map_wr_data),
    .trail_clear(trail_clear),
    .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .clear_busy(clear_busy), .cfg_err(cfg_err), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  int sh_w, sh_h, sh_lg, sh_sx, sh_sy, sh_fx, sh_fy, sh_cx, sh_cy;
  int m_fcnt;
  int m_left;           // sweep cycles still to run
  bit m_path  [1024];
  bit m_trail [1024];
  logic [7:0] d_rgb [3];
  logic       d_hs [3];
  logic       d_vs [3];
  bit         exp_ft;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int eff_lg();
    return (sh_lg < 2) ? 2 : ((sh_lg > 5) ? 5 : sh_lg);
  endfunction

  function automatic bit model_err();
    int t;
    t = 1 << eff_lg();
    return (sh_w * t > 640) || (sh_h * t > 480);
  endfunction

  // Colour of one pixel from the maze rules, ignoring enable and latency.
  function automatic logic [7:0] ref_color(input int x, input int y, input bit von);
    int t, mw, mh, bx, by, tx, ty, ox, oy, sub, r, c;
    bit corner;
    t  = 1 << eff_lg();
    mw = sh_w * t;
    mh = sh_h * t;
    if (!von || model_err()) return 8'h00;
    bx = (640 - mw) / 2;
    by = (480 - mh) / 2;
    if (x < bx || x >= bx + mw || y < by || y >= by + mh) return 8'h00;
    tx = (x - bx) / t;  ox = (x - bx) % t;
    ty = (y - by) / t;  oy = (y - by) % t;
    sub = t / 4;
    r = oy / sub;
    c = ox / sub;
    corner = (r == 0 || r == 3) && (c == 0 || c == 3);
    if (tx == sh_cx && ty == sh_cy && !corner) return C_CHAR;
    if (tx == sh_sx && ty == sh_sy) return C_START;
    if (tx == sh_fx && ty == sh_fy && ((m_fcnt / 16) % 2) == 0) return C_FINISH;
    if (m_path[ty*32 + tx] && m_trail[ty*32 + tx]) return C_TRAIL;
    if (m_path[ty*32 + tx]) return C_PATH;
    return 8'h00;
  endfunction

  // One clock: advance the model with the inputs sampled at this edge, then
  // compare every output 1 ns after the edge.
  task automatic step();
    logic [7:0] c;
    bit tk;
    hsync_in = 1'($urandom);
    vsync_in = 1'($urandom);
    c  = ref_color(int'(pixel_x), int'(pixel_y), video_on);
    tk = (pixel_x == 10'd0) && (pixel_y == 10'd480);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 3; i++) begin d_rgb[i] = 8'h00; d_hs[i] = 1'b1; d_vs[i] = 1'b1; end
      {sh_w, sh_h, sh_lg, sh_sx, sh_sy, sh_fx, sh_fy, sh_cx, sh_cy} = '0;
      m_fcnt = 0;
      m_left = 1024;
      exp_ft = 1'b0;
      for (int i = 0; i < 1024; i++) m_trail[i] = 1'b0;
    end else begin
      d_rgb[2] = enable ? d_rgb[1] : 8'h00;
      d_rgb[1] = d_rgb[0];
      d_rgb[0] = c;
      d_hs[2] = d_hs[1]; d_hs[1] = d_hs[0]; d_hs[0] = hsync_in;
      d_vs[2] = d_vs[1]; d_vs[1] = d_vs[0]; d_vs[0] = vsync_in;
      exp_ft = tk;
      if (tk) begin
        if (m_left == 0) m_trail[int'(char_y)*32 + int'(char_x)] = 1'b1;
        sh_w = cfg_maze_w;  sh_h = cfg_maze_h;  sh_lg = cfg_tile_log2;
        sh_sx = start_x;    sh_sy = start_y;
        sh_fx = finish_x;   sh_fy = finish_y;
        sh_cx = char_x;     sh_cy = char_y;
        m_fcnt = (m_fcnt + 1) % 32;
      end
      if (trail_clear) begin
        m_left = 1024;
        for (int i = 0; i < 1024; i++) m_trail[i] = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
      end
    end
    #1;
    chk("rgb", rgb, d_rgb[2]);
    chk("hsync", hsync, d_hs[2]);
    chk("vsync", vsync, d_vs[2]);
    chk("clear_busy", clear_busy, m_left > 0);
    chk("cfg_err", cfg_err, model_err());
    chk("frame_tick", frame_tick, exp_ft);
  endtask

  task automatic idle(input int n);
    pixel_x = 10'd700; pixel_y = 10'd500; video_on = 1'b0;
    repeat (n) step();
  endtask

  task automatic probe(input int x, input int y, input logic [7:0] exp, input string tag);
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = 1'b1;
    step();
    idle(2);
    chk(tag, rgb, exp);
  endtask

  task automatic do_tick();
    idle(3);
    pixel_x = 10'd0; pixel_y = 10'd480; video_on = 1'b0;
    step();
    chk("frame_tick_pulse", frame_tick, 1);
    idle(3);
  endtask

  task automatic set_cfg(input int w, input int h, input int lg, input int sx, input int sy,
                         input int fx, input int fy, input int cx, input int cy);
    cfg_maze_w = 5'(w); cfg_maze_h = 5'(h); cfg_tile_log2 = 3'(lg);
    start_x = 5'(sx);  start_y = 5'(sy);
    finish_x = 5'(fx); finish_y = 5'(fy);
    char_x = 5'(cx);   char_y = 5'(cy);
  endtask

  // Half the pixels land inside the currently latched maze box.
  task automatic rand_pixels(input int n);
    int t, mw, mh;
    t  = 1 << eff_lg();
    mw = sh_w * t;
    mh = sh_h * t;
    for (int i = 0; i < n; i++) begin
      if (($urandom % 2 == 0) && mw > 0 && mh > 0 && !model_err()) begin
        pixel_x = 10'($urandom_range((640 - mw) / 2, (640 - mw) / 2 + mw - 1));
        pixel_y = 10'($urandom_range((480 - mh) / 2, (480 - mh) / 2 + mh - 1));
      end else begin
        pixel_x = 10'($urandom_range(0, 639));
        pixel_y = 10'($urandom_range(0, 479));
      end
      video_on = ($urandom % 8) != 0;
      step();
    end
    idle(3);
  endtask

  // Counts consecutive observed cycles with clear_busy high, bounded.
  task automatic count_busy(output int n);
    int guard;
    n = 0;
    guard = 0;
    while (clear_busy === 1'b1 && guard < 3000) begin
      n++;
      step();
      guard++;
    end
  endtask

  int n_busy;

  initial begin
    reset = 1'b1; enable = 1'b1; trail_clear = 1'b0;
    map_wr_en = 1'b0; map_wr_addr = '0; map_wr_data = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    m_left = 1024; m_fcnt = 0;

    // Reset: outputs held at reset values, then the power-on sweep.
    idle(4);
    chk("reset_rgb", rgb, 0);
    chk("reset_hsync", hsync, 1);
    chk("reset_vsync", vsync, 1);
    reset = 1'b0;
    count_busy(n_busy);
    chk("reset_sweep_len", n_busy, 1024);

    // Fill the whole path RAM: row 0 and tile (5,5) are path, rest random.
    for (int a = 0; a < 1024; a++) begin
      map_wr_en = 1'b1;
      map_wr_addr = 10'(a);
      map_wr_data = (a < 8) || (a == 5*32 + 5) || ($urandom % 3 == 0);
      m_path[a] = map_wr_data;
      pixel_x = 10'($urandom_range(0, 639)); pixel_y = 10'($urandom_range(0, 479));
      video_on = 1'b1;
      step();
    end
    map_wr_en = 1'b0;
    idle(3);

    // 8x8 maze of 16-pixel tiles, border 256/176, char away from row 0.
    set_cfg(8, 8, 4, 0, 0, 7, 0, 5, 5);
    do_tick();
    probe(304, 176, C_PATH,   "path_before_trail");
    probe(260, 180, C_START,  "start_tile");
    probe(344, 264, C_CHAR,   "char_sprite");
    probe(376, 184, C_FINISH, "finish_visible");
    probe(255, 180, 8'h00,    "left_of_border");
    probe(384, 180, 8'h00,    "right_of_border");
    rand_pixels(300);

    // Move char to (3,0): its tile is marked at the next frame_tick.
    char_x = 5'd3; char_y = 5'd0;
    do_tick();
    probe(304, 176, C_TRAIL, "char_corner_trail");
    probe(305, 180, C_CHAR,  "char_sprite_r1c0");
    probe(336, 256, C_TRAIL, "old_char_trail");
    enable = 1'b0;
    idle(3);
    probe(305, 180, 8'h00, "enable_off");
    enable = 1'b1;
    idle(3);

    // Char input changes mid-frame: no effect before the next tick.
    char_x = 5'd6;
    rand_pixels(200);
    probe(305, 180, C_CHAR, "char_held_midframe");
    char_x = 5'd3;

    // Blinking finish tile across 64 frames.
    for (int f = 0; f < 64; f++) begin
      do_tick();
      probe(376, 184, ((m_fcnt / 16) % 2 == 0) ? C_FINISH : C_PATH, "finish_blink");
    end

    // Oversized maze, then the exact-fit boundary.
    set_cfg(21, 8, 5, 0, 0, 7, 0, 3, 0);
    do_tick();
    chk("cfg_err_set", cfg_err, 1);
    rand_pixels(100);
    cfg_maze_w = 5'd20;
    do_tick();
    chk("cfg_err_clear", cfg_err, 0);
    probe(0, 112, C_START, "full_width_left");
    rand_pixels(200);

    // Random configurations including clamped tile sizes.
    for (int k = 0; k < 6; k++) begin
      int w, h;
      w = $urandom_range(1, 31);
      h = $urandom_range(1, 31);
      set_cfg(w, h, $urandom_range(0, 7),
              $urandom_range(0, w-1), $urandom_range(0, h-1),
              $urandom_range(0, w-1), $urandom_range(0, h-1),
              $urandom_range(0, w-1), $urandom_range(0, h-1));
      do_tick();
      rand_pixels(250);
    end

    // Trail clear: a mark during the sweep is dropped, a second pulse restarts.
    set_cfg(8, 8, 4, 0, 0, 7, 0, 3, 0);
    do_tick();
    trail_clear = 1'b1;
    step();
    trail_clear = 1'b0;
    char_x = 5'd2;
    do_tick();
    idle(492);
    trail_clear = 1'b1;
    step();
    trail_clear = 1'b0;
    count_busy(n_busy);
    chk("restart_sweep_len", n_busy, 1024);
    probe(288, 176, C_PATH, "mark_dropped");
    probe(304, 176, C_PATH, "trail_cleared");
    rand_pixels(200);

    // Reset mid-sweep and mid-frame.
    trail_clear = 1'b1;
    step();
    trail_clear = 1'b0;
    rand_pixels(100);
    pixel_x = 10'd300; pixel_y = 10'd200; video_on = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    count_busy(n_busy);
    chk("reset2_sweep_len", n_busy, 1024);
    rand_pixels(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
